// File: rtl/mips32_prog_loader.sv
// Program loader: collects a big-endian byte stream into 32-bit words, writes
// them to consecutive word addresses of the CPU instruction memory, holds the
// CPU halted during the load and pulses cpu_start once the load completes.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | after reset; CPU held, waiting for a load request
// COLLECT  | accepting bytes of the current word (in_ready=1)
// WRITE    | one-cycle memory write of the assembled word
// RELEASE  | one-cycle cpu_start pulse, CPU released
// DONE     | load finished, CPU running, a new start may begin another load
module mips32_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_halt,
  output logic              cpu_start,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       partial;

  logic start_ok;
  logic xfer;
  logic last_word;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign xfer      = in_valid && (state == S_COLLECT);
  assign last_word = (word_idx == (count_q - ONE));

  // State register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    cpu_start = 1'b0;
    cpu_halt  = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE) begin
          cpu_halt = 1'b0;
          done     = 1'b1;
        end
        if (start) begin
          state_nxt = (word_count == '0) ? S_RELEASE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && (byte_idx == 2'd3)) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        busy      = 1'b1;
        state_nxt = last_word ? S_RELEASE : S_COLLECT;
      end
      S_RELEASE: begin
        cpu_start = 1'b1;
        cpu_halt  = 1'b0;
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Load parameters, byte/word indices and word assembly. The write address
  // and data are registered on the 4th byte so they are stable throughout
  // WRITE and simply hold afterwards.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      count_q   <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      partial   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (start_ok) begin
        base_q   <= base_addr;
        count_q  <= word_count;
        word_idx <= '0;
        byte_idx <= '0;
        partial  <= '0;
      end
      if (xfer) begin
        byte_idx <= byte_idx + 2'd1;
        partial  <= {partial[15:0], in_byte};
        if (byte_idx == 2'd3) begin
          mem_addr  <= base_q + word_idx[ADDR_W-1:0];
          mem_wdata <= {partial, in_byte};
        end
      end
      if ((state == S_WRITE) && !last_word) begin
        word_idx <= word_idx + ONE;
      end
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: a table of single-word loads plus
// hand-written multi-word, stall, wrap, zero-count and reset sequences.
module tb_mips32_prog_loader;
  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = '0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_halt;
  logic          cpu_start;
  logic          busy;
  logic          done;

  mips32_prog_loader #(.ADDR_W(AW)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_halt(cpu_halt), .cpu_start(cpu_start),
    .busy(busy), .done(done)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int s_cyc = 0;

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          cs_cyc_q[$];

  // Log every write and every cpu_start cycle, sampled mid-cycle.
  always @(negedge clk1) begin
    cyc = cyc + 1;
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (cpu_start) cs_cyc_q.push_back(cyc);
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [31:0]   stream;     // bytes sent MSB first
    int            exp_addr;
    logic [31:0]   exp_data;
  } vec_t;

  vec_t vecs[4];

  logic [31:0] prog8[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    cs_cyc_q.delete();
  endtask

  // s_cyc = logged cycle number of the first cycle after the start edge.
  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc + 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int w;
    in_valid = 1'b1;
    in_byte  = b;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout: in_ready=0 expected 1");
      in_valid = 1'b0;
      return;
    end
    tick();
    if (gap) begin
      in_valid = 1'b0;
      in_byte  = 8'hff;
      tick();
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done && w < 100) begin
      tick();
      w++;
    end
    check("done_reached", done, 1'b1);
  endtask

  task automatic check_writes(input string name, input int n, input int a0, input logic [31:0] d0);
    check({name, "_wr_count"}, wr_addr_q.size(), n);
    if (wr_addr_q.size() > 0) begin
      check({name, "_addr"}, wr_addr_q[0], a0);
      check({name, "_data"}, wr_data_q[0], d0);
    end
  endtask

  initial begin
    vecs[0] = '{10'd0,    32'h28010078, 0,    32'h28010078};
    vecs[1] = '{10'd5,    32'h0c631800, 5,    32'h0c631800};
    vecs[2] = '{10'd1023, 32'hfc000000, 1023, 32'hfc000000};
    vecs[3] = '{10'd512,  32'hdeadbeef, 512,  32'hdeadbeef};
    prog8 = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
              32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};

    // Reset values.
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_halt", cpu_halt, 1'b1);
    check("rst_cpu_start", cpu_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Single word; start accepted on the first edge after reset release.
    clear_log();
    rst_n = 1'b1;
    do_start(10'd0, 11'd1);
    check("first_start_busy", busy, 1'b1);
    check("load_cpu_halt", cpu_halt, 1'b1);
    send_word(32'h28010078, 1'b0);
    in_valid = 1'b0;
    wait_done();
    check_writes("single", 1, 0, 32'h28010078);
    if (wr_cyc_q.size() > 0)
      check("single_wr_latency", wr_cyc_q[0] - s_cyc, 4);
    check("single_cs_count", cs_cyc_q.size(), 1);
    if (cs_cyc_q.size() > 0 && wr_cyc_q.size() > 0)
      check("single_cs_after_wr", cs_cyc_q[0] - wr_cyc_q[0], 1);
    check("single_halt_released", cpu_halt, 1'b0);
    check("single_not_busy", busy, 1'b0);

    // Table of single-word loads, each restarted from DONE.
    for (int i = 0; i < 4; i++) begin
      clear_log();
      do_start(vecs[i].base, 11'd1);
      send_word(vecs[i].stream, 1'b0);
      in_valid = 1'b0;
      wait_done();
      check_writes($sformatf("vec%0d", i), 1, vecs[i].exp_addr, vecs[i].exp_data);
      check($sformatf("vec%0d_hold_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_hold_data", i), mem_wdata, vecs[i].exp_data);
      check($sformatf("vec%0d_halt", i), cpu_halt, 1'b0);
    end

    // Eight words back-to-back: 5 cycles per word, no gaps.
    clear_log();
    do_start(10'd0, 11'd8);
    for (int i = 0; i < 8; i++) send_word(prog8[i], 1'b0);
    in_valid = 1'b0;
    wait_done();
    check("eight_wr_count", wr_addr_q.size(), 8);
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      check($sformatf("eight_addr%0d", i), wr_addr_q[i], i);
      check($sformatf("eight_data%0d", i), wr_data_q[i], prog8[i]);
      if (i > 0) check($sformatf("eight_gap%0d", i), wr_cyc_q[i] - wr_cyc_q[i-1], 5);
    end
    if (wr_cyc_q.size() == 8)
      check("eight_last_wr_latency", wr_cyc_q[7] - s_cyc, 39);
    check("eight_cs_count", cs_cyc_q.size(), 1);

    // Stalled stream with a start pulse while collecting.
    clear_log();
    do_start(10'd0, 11'd1);
    send_byte(8'h28, 1'b1);
    send_byte(8'h01, 1'b1);
    check("stall_in_collect", in_ready, 1'b1);
    base_addr  = 10'd100;
    word_count = 11'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1);
    wait_done();
    check_writes("stall", 1, 0, 32'h28010078);
    check("stall_cs_count", cs_cyc_q.size(), 1);

    // Address wrap-around.
    clear_log();
    do_start(10'd1023, 11'd2);
    send_word(32'h11223344, 1'b0);
    send_word(32'h55667788, 1'b0);
    in_valid = 1'b0;
    wait_done();
    check_writes("wrap", 2, 1023, 32'h11223344);
    if (wr_addr_q.size() > 1) begin
      check("wrap_addr1", wr_addr_q[1], 0);
      check("wrap_data1", wr_data_q[1], 32'h55667788);
    end

    // Zero count: straight to RELEASE, no writes.
    clear_log();
    do_start(10'd3, 11'd0);
    check("zero_cpu_start", cpu_start, 1'b1);
    check("zero_cpu_halt", cpu_halt, 1'b0);
    wait_done();
    check("zero_wr_count", wr_addr_q.size(), 0);
    check("zero_cs_count", cs_cyc_q.size(), 1);
    if (cs_cyc_q.size() > 0) check("zero_cs_cycle", cs_cyc_q[0] - s_cyc, 0);

    // Reset after two bytes of word 0.
    clear_log();
    do_start(10'd0, 11'd2);
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    check("mid_rst_halt", cpu_halt, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("mid_rst_no_wr", wr_addr_q.size(), 0);
    check("mid_rst_halt_after", cpu_halt, 1'b1);
    check("mid_rst_idle", {busy, done, in_ready}, 3'b000);
    do_start(10'd7, 11'd1);
    send_word(32'h0c631800, 1'b0);
    in_valid = 1'b0;
    wait_done();
    check_writes("post_rst", 1, 7, 32'h0c631800);
    check("post_rst_halt", cpu_halt, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
